count8_ld: RTL and testbench

8-bit synchronous up-counter with parallel load, count enable and asynchronous active-low clear. It is a general-purpose counter leaf cell used wherever a presettable 8-bit event or step count is needed. It has one clock domain and no handshake. All candidate implementations must be cycle-identical to each other at the `CNT` output.

---
 rtl/count8_ld_pkg.sv | 10 +
 rtl/count8_ld_if.sv | 24 ++
 rtl/count8_ld_bit_slice.sv | 34 +++
 rtl/count8_ld.sv | 37 +++
 tb/tb_count8_ld.sv | 135 +++++++++++++
 5 files changed

// File: rtl/count8_ld_pkg.sv
// Shared width and reset constants for the presettable 8-bit counter.
package count8_ld_pkg;

    localparam int unsigned CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_RST = 8'h00;

endpackage

// File: rtl/count8_ld_if.sv
// Control and count bus of count8_ld: enable, parallel load and current count.
interface count8_ld_if;
    import count8_ld_pkg::*;

    logic EN;
    logic load;
    cnt_t CNT_In;
    cnt_t CNT;

    modport master (
        output EN,
        output load,
        output CNT_In,
        input  CNT
    );

    modport slave (
        input  EN,
        input  load,
        input  CNT_In,
        output CNT
    );

endinterface

// File: rtl/count8_ld_bit_slice.sv
// One counter bit: toggle-on-carry flop with parallel-load mux and async active-low clear.
module count8_ld_bit_slice #(
    parameter bit RstVal = 1'b0
) (
    input  logic clk,
    input  logic res,
    input  logic en,
    input  logic load,
    input  logic d_in,
    input  logic carry_in,
    output logic q
);

    logic toggle;
    logic q_d;

    assign toggle = en & carry_in;

    always_comb begin
        q_d = q ^ toggle;
        if (load) begin
            q_d = d_in;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            q <= RstVal;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/count8_ld.sv
// 8-bit up-counter with parallel load (priority over enable) built from ripple-carry bit slices.
module count8_ld
    import count8_ld_pkg::*;
(
    input  logic         clk,
    input  logic         res,
    count8_ld_if.slave   bus
);

    cnt_t q;
    cnt_t carry;

    // Bit i toggles only when every lower bit is 1; slice 0 always sees carry-in = 1.
    always_comb begin
        carry[0] = 1'b1;
        for (int i = 1; i < CNT_W; i++) begin
            carry[i] = carry[i-1] & q[i-1];
        end
    end

    for (genvar i = 0; i < CNT_W; i++) begin : g_slice
        count8_ld_bit_slice #(
            .RstVal (CNT_RST[i])
        ) u_slice (
            .clk      (clk),
            .res      (res),
            .en       (bus.EN),
            .load     (bus.load),
            .d_in     (bus.CNT_In[i]),
            .carry_in (carry[i]),
            .q        (q[i])
        );
    end

    assign bus.CNT = q;

endmodule

// File: tb/tb_count8_ld.sv
// Directed and randomized checks of count8_ld against an arithmetic reference model.
module tb_count8_ld;

    logic clk;
    logic res;
    int   total;
    int   bad;
    int   model;

    count8_ld_if bus ();

    count8_ld dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, got, exp);
        end
    endtask

    // Reference: load wins, else enable adds one modulo 256, else hold; reset forces zero.
    initial model = 0;
    always @(posedge clk) begin
        if (res === 1'b1) begin
            if (bus.load) model = bus.CNT_In;
            else if (bus.EN) model = (model + 1) % 256;
        end else begin
            model = 0;
        end
    end
    always @(negedge res) model = 0;

    always @(clk) begin
        #2;
        check("model", bus.CNT, model[7:0]);
    end

    task automatic edge_check(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #2;
        check(tag, bus.CNT, exp);
    endtask

    initial begin
        total = 0;
        bad = 0;
        res = 1'b0;
        bus.EN = 1'b1;
        bus.load = 1'b0;
        bus.CNT_In = 8'h00;
        #2;
        check("reset", bus.CNT, 8'h00);
        #2 res = 1'b1;
        edge_check("count1", 8'h01);
        edge_check("count2", 8'h02);

        #37;
        bus.load = 1'b1;
        bus.CNT_In = 8'h11;
        edge_check("load1", 8'h11);
        edge_check("load_held", 8'h11);
        bus.load = 1'b0;
        bus.CNT_In = 8'h00;
        edge_check("after_load1", 8'h12);
        edge_check("after_load2", 8'h13);

        bus.EN = 1'b0;
        edge_check("hold1", 8'h13);
        edge_check("hold2", 8'h13);
        edge_check("hold3", 8'h13);
        bus.EN = 1'b1;
        edge_check("resume", 8'h14);

        bus.EN = 1'b0;
        bus.load = 1'b1;
        bus.CNT_In = 8'hA5;
        edge_check("load_en_lo", 8'hA5);
        bus.load = 1'b0;
        edge_check("load_hold", 8'hA5);

        bus.load = 1'b1;
        bus.CNT_In = 8'hFE;
        edge_check("load_fe", 8'hFE);
        bus.load = 1'b0;
        bus.EN = 1'b1;
        edge_check("wrap_ff", 8'hFF);
        edge_check("wrap_00", 8'h00);
        edge_check("wrap_01", 8'h01);

        bus.EN = 1'b0;
        bus.load = 1'b1;
        bus.CNT_In = 8'h37;
        edge_check("load_37", 8'h37);
        bus.load = 1'b0;
        bus.EN = 1'b1;
        #8 res = 1'b0;
        #1;
        check("async_clr", bus.CNT, 8'h00);
        edge_check("rst_held1", 8'h00);
        edge_check("rst_held2", 8'h00);
        @(negedge clk);
        #2 res = 1'b1;
        edge_check("post_rst", 8'h01);

        // Random traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            bus.EN = 1'($urandom_range(0, 1));
            bus.load = ($urandom_range(0, 3) == 0);
            bus.CNT_In = 8'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                #4 res = 1'b0;
                #1;
                check("rand_clr", bus.CNT, 8'h00);
                #4 res = 1'b1;
            end
        end
        @(posedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
